// File: rtl/hilo_mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_mdu_ctrl_pkg : MDU op/state encodings and operand helper   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package hilo_mdu_ctrl_pkg;

   localparam int DATALENGTH = 32;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   // Magnitude of a two's-complement value; 0x80000000 maps to itself, which is
   // the correct unsigned magnitude.
   function automatic logic [DATALENGTH-1:0] mag(input logic [DATALENGTH-1:0] v,
                                                  input logic                  is_signed);
      return (is_signed && v[DATALENGTH-1]) ? -v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter : restoring radix-2 unsigned divider, one quotient bit per cycle (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module div_iter
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [DATALENGTH-1:0] dividend,
   input  logic [DATALENGTH-1:0] divisor,
   output logic [DATALENGTH-1:0] quotient,
   output logic [DATALENGTH-1:0] remainder,
   output logic                  done
);

   localparam int CW = $clog2(DIV_CYCLES);

   logic                  busy_q;
   logic [CW-1:0]         cnt_q;
   logic [DATALENGTH-1:0] rem_q;
   logic [DATALENGTH-1:0] quo_q;
   logic [DATALENGTH-1:0] div_q;

   logic [DATALENGTH:0]   partial;
   logic                  ge;
   logic [DATALENGTH-1:0] diff;

   // Outputs carry the result of the step being taken this cycle, so the final
   // quotient/remainder are usable on the same edge that retires the last step.
   assign partial   = {rem_q, quo_q[DATALENGTH-1]};
   assign ge        = partial >= {1'b0, div_q};
   assign diff      = partial[DATALENGTH-1:0] - div_q;
   assign remainder = ge ? diff : partial[DATALENGTH-1:0];
   assign quotient  = {quo_q[DATALENGTH-2:0], ge};
   assign done      = busy_q && (cnt_q == CW'(DIV_CYCLES - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= dividend;
         div_q  <= divisor;
      end else if (busy_q) begin
         rem_q <= remainder;
         quo_q <= quotient;
         cnt_q <= cnt_q + CW'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mdu_ctrl : HI/LO owner sequencing MULT/MULTU/DIV/DIVU/MTHI/MTLO (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_mdu_ctrl
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  StartE,
   input  logic [2:0]            OpE,
   input  logic [DATALENGTH-1:0] SrcAE,
   input  logic [DATALENGTH-1:0] SrcBE,
   input  logic                  FlushE,
   input  logic                  HiloReadE,
   input  logic                  HiloSelE,
   output logic [DATALENGTH-1:0] HilodataE,
   output logic                  MduStall,
   output logic                  MduBusy
);

   mdu_state_e            state_q;
   logic [DATALENGTH-1:0] hi_q;
   logic [DATALENGTH-1:0] lo_q;
   logic [DATALENGTH-1:0] a_q;
   logic [DATALENGTH-1:0] b_q;
   logic                  signed_q;
   logic                  sign_a_q;
   logic                  neg_q;
   logic                  divzero_q;

   logic                  accept;
   logic                  op_signed;
   logic                  div_start;
   logic signed [DATALENGTH:0] mul_a;
   logic signed [DATALENGTH:0] mul_b;
   logic [2*DATALENGTH-1:0]    prod;
   logic                  div_done;
   logic [DATALENGTH-1:0] div_quo;
   logic [DATALENGTH-1:0] div_rem;
   logic [DATALENGTH-1:0] hi_d;
   logic [DATALENGTH-1:0] lo_d;

   assign MduBusy   = (state_q != ST_IDLE);
   assign MduStall  = MduBusy & (HiloReadE | StartE);
   assign HilodataE = HiloSelE ? hi_q : lo_q;

   assign accept    = StartE & ~FlushE & ~MduBusy;
   assign op_signed = (OpE == MDU_MULT) || (OpE == MDU_DIV);
   assign div_start = accept && ((OpE == MDU_DIV) || (OpE == MDU_DIVU));

   // 33-bit operands let one signed multiplier serve both MULT and MULTU.
   assign mul_a = {signed_q & a_q[DATALENGTH-1], a_q};
   assign mul_b = {signed_q & b_q[DATALENGTH-1], b_q};
   assign prod  = 64'(mul_a) * 64'(mul_b);

   div_iter #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_iter (
      .clock     (clock),
      .resetn    (resetn),
      .start     (div_start),
      .dividend  (mag(SrcAE, op_signed)),
      .divisor   (mag(SrcBE, op_signed)),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_comb begin
      hi_d = prod[2*DATALENGTH-1:DATALENGTH];
      lo_d = prod[DATALENGTH-1:0];
      if (state_q == ST_DIV) begin
         if (divzero_q) begin
            hi_d = a_q;
            lo_d = '1;
         end else begin
            hi_d = sign_a_q ? -div_rem : div_rem;
            lo_d = neg_q    ? -div_quo : div_quo;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         signed_q  <= 1'b0;
         sign_a_q  <= 1'b0;
         neg_q     <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (OpE)
                     MDU_MULT, MDU_MULTU: begin
                        a_q      <= SrcAE;
                        b_q      <= SrcBE;
                        signed_q <= op_signed;
                        state_q  <= ST_MUL;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        a_q       <= SrcAE;
                        sign_a_q  <= op_signed & SrcAE[DATALENGTH-1];
                        neg_q     <= op_signed & (SrcAE[DATALENGTH-1] ^ SrcBE[DATALENGTH-1]);
                        divzero_q <= (SrcBE == '0);
                        state_q   <= ST_DIV;
                     end
                     MDU_MTHI: hi_q <= SrcAE;
                     MDU_MTLO: lo_q <= SrcAE;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               state_q <= ST_IDLE;
            end
            ST_DIV: begin
               if (div_done) begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu_ctrl : directed scoreboard bench for hilo_mdu_ctrl     (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hilo_mdu_ctrl;
   import hilo_mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        StartE;
   logic [2:0]  OpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        FlushE;
   logic        HiloReadE;
   logic        HiloSelE;
   logic [31:0] HilodataE;
   logic        MduStall;
   logic        MduBusy;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] exp_val_q[$];
   string       exp_name_q[$];

   hilo_mdu_ctrl #(.DIV_CYCLES(32)) dut (
      .clock     (clk),
      .resetn    (resetn),
      .StartE    (StartE),
      .OpE       (OpE),
      .SrcAE     (SrcAE),
      .SrcBE     (SrcBE),
      .FlushE    (FlushE),
      .HiloReadE (HiloReadE),
      .HiloSelE  (HiloSelE),
      .HilodataE (HilodataE),
      .MduStall  (MduStall),
      .MduBusy   (MduBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: a read is presented whenever MFHI/MFLO sits in E without a stall.
   always @(negedge clk) begin
      if (resetn && HiloReadE && !MduStall) begin
         if (exp_val_q.size() == 0) begin
            check("unexpected read", HilodataE, 32'hxxxxxxxx);
         end else begin
            check(exp_name_q.pop_front(), HilodataE, exp_val_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_while_stalled(output int stalls);
      stalls = 0;
      while (MduStall && stalls < 100) begin
         tick();
         stalls++;
      end
      if (MduStall) check("stall timeout", 32'(stalls), 32'd0);
   endtask

   task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic flush, output int stalls);
      StartE = 1'b1;
      OpE    = op;
      SrcAE  = a;
      SrcBE  = b;
      FlushE = flush;
      hold_while_stalled(stalls);
      tick();
      StartE = 1'b0;
      FlushE = 1'b0;
   endtask

   task automatic do_read(input logic sel, input logic [31:0] exp, input string name,
                          output int stalls);
      HiloReadE = 1'b1;
      HiloSelE  = sel;
      exp_val_q.push_back(exp);
      exp_name_q.push_back(name);
      hold_while_stalled(stalls);
      tick();
      HiloReadE = 1'b0;
   endtask

   task automatic busy_cycles(output int n);
      n = 0;
      while (MduBusy && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int st;
      int nb;
      resetn    = 1'b0;
      StartE    = 1'b0;
      OpE       = MDU_MULT;
      SrcAE     = '0;
      SrcBE     = '0;
      FlushE    = 1'b0;
      HiloReadE = 1'b0;
      HiloSelE  = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      check("reset busy", 32'(MduBusy), 32'd0);
      check("reset stall", 32'(MduStall), 32'd0);
      do_read(1'b0, 32'h0, "reset LO", st);
      do_read(1'b1, 32'h0, "reset HI", st);
      check("idle read stall", 32'(st), 32'd0);

      issue(MDU_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, st);
      busy_cycles(nb);
      check("MULT busy cycles", 32'(nb), 32'd1);
      do_read(1'b1, 32'hFFFFFFFF, "MULT HI", st);
      do_read(1'b0, 32'hFFFFFFFE, "MULT LO", st);

      issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, st);
      do_read(1'b1, 32'h00000001, "MULTU HI", st);
      check("MULTU read stall", 32'(st), 32'd1);
      do_read(1'b0, 32'hFFFFFFFE, "MULTU LO", st);

      issue(MDU_DIVU, 32'd100, 32'd7, 1'b0, st);
      do_read(1'b0, 32'h0000000E, "DIVU LO", st);
      check("DIVU MFLO stall cycles", 32'(st), 32'd32);
      do_read(1'b1, 32'h00000002, "DIVU HI", st);
      check("post-div read stall", 32'(st), 32'd0);

      issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, st);
      do_read(1'b0, 32'hFFFFFFFD, "DIV -7/2 LO", st);
      do_read(1'b1, 32'hFFFFFFFF, "DIV -7/2 HI", st);

      issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, st);
      do_read(1'b0, 32'h80000000, "DIV wrap LO", st);
      do_read(1'b1, 32'h00000000, "DIV wrap HI", st);

      issue(MDU_DIV, 32'h12345678, 32'd0, 1'b0, st);
      busy_cycles(nb);
      check("DIV by zero busy cycles", 32'(nb), 32'd32);
      do_read(1'b0, 32'hFFFFFFFF, "DIV0 LO", st);
      do_read(1'b1, 32'h12345678, "DIV0 HI", st);

      issue(MDU_DIVU, 32'hFFFFFFFF, 32'h00000010, 1'b0, st);
      do_read(1'b0, 32'h0FFFFFFF, "DIVU max LO", st);
      do_read(1'b1, 32'h0000000F, "DIVU max HI", st);

      issue(MDU_MTHI, 32'hDEADBEEF, 32'd0, 1'b1, st);
      check("flushed op busy", 32'(MduBusy), 32'd0);
      do_read(1'b1, 32'h0000000F, "flushed MTHI HI", st);
      issue(MDU_MTHI, 32'hDEADBEEF, 32'd0, 1'b0, st);
      do_read(1'b1, 32'hDEADBEEF, "MTHI HI", st);
      check("MTHI read stall", 32'(st), 32'd0);
      issue(MDU_MTLO, 32'h13579BDF, 32'd0, 1'b0, st);
      do_read(1'b0, 32'h13579BDF, "MTLO LO", st);
      do_read(1'b1, 32'hDEADBEEF, "MTLO keeps HI", st);

      issue(MDU_MULT, 32'd3, 32'd5, 1'b0, st);
      issue(MDU_DIV, 32'd20, 32'hFFFFFFFD, 1'b0, st);
      check("DIV behind MULT stall", 32'(st), 32'd1);
      do_read(1'b0, 32'hFFFFFFFA, "MULT then DIV LO", st);
      check("MULT then DIV read stall", 32'(st), 32'd32);
      do_read(1'b1, 32'h00000002, "MULT then DIV HI", st);

      issue(MDU_DIVU, 32'd100, 32'd7, 1'b0, st);
      repeat (9) tick();
      resetn = 1'b0;
      #1;
      check("mid-op reset busy", 32'(MduBusy), 32'd0);
      HiloSelE = 1'b1;
      #1;
      check("mid-op reset HI", HilodataE, 32'h0);
      HiloSelE = 1'b0;
      #1;
      check("mid-op reset LO", HilodataE, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) tick();
      check("post-reset busy", 32'(MduBusy), 32'd0);
      do_read(1'b0, 32'h0, "post-reset LO", st);
      do_read(1'b1, 32'h0, "post-reset HI", st);

      tick();
      check("scoreboard drained", 32'(exp_val_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
